// File: rtl/rf_wb_scheduler_if.sv
// Bus bundle between the issue stage / writeback sources and the register-file write scheduler.
// The master side drives issue and writeback requests; the scheduler is the slave.
interface rf_wb_scheduler_if #(
   parameter int unsigned DW    = 32,
   parameter int unsigned AW    = 5,
   parameter int unsigned NREGS = 32
);
   logic             iss_valid;
   logic [AW-1:0]    iss_rs1;
   logic [AW-1:0]    iss_rs2;
   logic [AW-1:0]    iss_rd;
   logic             iss_rd_we;
   logic             iss_stall;

   logic             a_valid;
   logic [AW-1:0]    a_rd;
   logic [DW-1:0]    a_data;
   logic             a_ready;

   logic             b_valid;
   logic [AW-1:0]    b_rd;
   logic [DW-1:0]    b_data;
   logic             b_ready;

   logic             rf_we;
   logic [AW-1:0]    rf_adr_wrt;
   logic [DW-1:0]    rf_data_in;
   logic [NREGS-1:0] busy_vec;

   modport master (
      output iss_valid, iss_rs1, iss_rs2, iss_rd, iss_rd_we,
      output a_valid, a_rd, a_data,
      output b_valid, b_rd, b_data,
      input  iss_stall, a_ready, b_ready,
      input  rf_we, rf_adr_wrt, rf_data_in, busy_vec
   );

   modport slave (
      input  iss_valid, iss_rs1, iss_rs2, iss_rd, iss_rd_we,
      input  a_valid, a_rd, a_data,
      input  b_valid, b_rd, b_data,
      output iss_stall, a_ready, b_ready,
      output rf_we, rf_adr_wrt, rf_data_in, busy_vec
   );
endinterface

// File: rtl/rf_wb_scheduler.sv
// Round-robin scheduler for the register file's single write port (ALU vs load/store)
// plus a per-register busy scoreboard that stalls issue on RAW/WAW hazards.
module rf_wb_scheduler #(
   parameter int unsigned DW    = 32,
   parameter int unsigned AW    = 5,
   parameter int unsigned NREGS = 32
) (
   input  logic              clk,
   input  logic              reset,
   rf_wb_scheduler_if.slave  bus
);

   logic [NREGS-1:0] r_busy;
   logic             r_rr_last_b;
   logic             r_rf_we;
   logic [AW-1:0]    r_rf_adr;
   logic [DW-1:0]    r_rf_data;

   logic [NREGS-1:0] w_busy;
   logic [NREGS-1:0] w_busy_nxt;
   logic             w_stall;
   logic             w_fire;
   logic             w_gnt_a;
   logic             w_gnt_b;
   logic             w_gnt;
   logic [AW-1:0]    w_gnt_rd;
   logic [DW-1:0]    w_gnt_data;

   // x0 never reports busy, whatever the register holds
   assign w_busy = {r_busy[NREGS-1:1], 1'b0};

   assign w_stall = ~reset & bus.iss_valid &
                    (w_busy[bus.iss_rs1] | w_busy[bus.iss_rs2] |
                     (bus.iss_rd_we & w_busy[bus.iss_rd]));
   assign w_fire  = ~reset & bus.iss_valid & ~w_stall;

   // Contention goes to the source that did not win last
   assign w_gnt_a    = ~reset & bus.a_valid & (~bus.b_valid | r_rr_last_b);
   assign w_gnt_b    = ~reset & bus.b_valid & (~bus.a_valid | ~r_rr_last_b);
   assign w_gnt      = w_gnt_a | w_gnt_b;
   assign w_gnt_rd   = w_gnt_a ? bus.a_rd   : bus.b_rd;
   assign w_gnt_data = w_gnt_a ? bus.a_data : bus.b_data;

   // Clear applied before set so an issue on the commit edge keeps the register busy
   always_comb begin
      w_busy_nxt = r_busy;
      if (r_rf_we) begin
         w_busy_nxt[r_rf_adr] = 1'b0;
      end
      if (w_fire && bus.iss_rd_we && (bus.iss_rd != '0)) begin
         w_busy_nxt[bus.iss_rd] = 1'b1;
      end
      w_busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_busy      <= '0;
         r_rr_last_b <= 1'b1;
         r_rf_we     <= 1'b0;
         r_rf_adr    <= '0;
         r_rf_data   <= '0;
      end else begin
         r_busy  <= w_busy_nxt;
         r_rf_we <= w_gnt && (w_gnt_rd != '0);
         if (w_gnt) begin
            r_rr_last_b <= w_gnt_b;
            r_rf_adr    <= w_gnt_rd;
            r_rf_data   <= w_gnt_data;
         end
      end
   end

   assign bus.iss_stall  = w_stall;
   assign bus.a_ready    = w_gnt_a;
   assign bus.b_ready    = w_gnt_b;
   assign bus.rf_we      = r_rf_we;
   assign bus.rf_adr_wrt = r_rf_adr;
   assign bus.rf_data_in = r_rf_data;
   assign bus.busy_vec   = r_busy;

   a_one_hot_ready: assert property (@(posedge clk) disable iff (reset)
      !(bus.a_ready && bus.b_ready));
   a_grant_a_busy: assert property (@(posedge clk) disable iff (reset)
      (bus.a_ready && (bus.a_rd != '0)) |-> w_busy[bus.a_rd]);
   a_grant_b_busy: assert property (@(posedge clk) disable iff (reset)
      (bus.b_ready && (bus.b_rd != '0)) |-> w_busy[bus.b_rd]);

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed bench for rf_wb_scheduler: writeback arbitration, write stage timing,
// scoreboard hazards, x0 handling and asynchronous reset.
module tb_rf_wb_scheduler;

   localparam int unsigned DW    = 32;
   localparam int unsigned AW    = 5;
   localparam int unsigned NREGS = 32;

   logic clk;
   logic reset;
   int   n_vec;
   int   n_err;

   rf_wb_scheduler_if #(.DW(DW), .AW(AW), .NREGS(NREGS)) bus ();

   rf_wb_scheduler #(.DW(DW), .AW(AW), .NREGS(NREGS)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic we);
      bus.iss_valid = 1'b1;
      bus.iss_rs1   = rs1;
      bus.iss_rs2   = rs2;
      bus.iss_rd    = rd;
      bus.iss_rd_we = we;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      logic [4:0]  exp_adr [4];
      logic [31:0] exp_dat [4];
      logic        exp_ga  [4];

      n_vec = 0;
      n_err = 0;
      reset = 1'b1;
      bus.iss_valid = 1'b0; bus.iss_rs1 = '0; bus.iss_rs2 = '0;
      bus.iss_rd = '0; bus.iss_rd_we = 1'b0;
      bus.a_valid = 1'b0; bus.a_rd = '0; bus.a_data = '0;
      bus.b_valid = 1'b0; bus.b_rd = '0; bus.b_data = '0;
      tick();
      tick();
      chk("rst busy_vec", 64'(bus.busy_vec), 64'h0);
      chk("rst rf_we", 64'(bus.rf_we), 64'h0);
      chk("rst rf_adr", 64'(bus.rf_adr_wrt), 64'h0);
      chk("rst rf_data", 64'(bus.rf_data_in), 64'h0);
      reset = 1'b0;

      // single ALU write to x5
      issue(5'd0, 5'd0, 5'd5, 1'b1);
      #1 chk("t2 issue stall", 64'(bus.iss_stall), 64'h0);
      tick();
      chk("t2 busy set", 64'(bus.busy_vec), 64'h0000_0020);
      bus.iss_valid = 1'b0;
      bus.a_valid = 1'b1; bus.a_rd = 5'd5; bus.a_data = 32'hDEAD_BEEF;
      #1 chk("t2 a_ready", 64'(bus.a_ready), 64'h1);
      chk("t2 b_ready", 64'(bus.b_ready), 64'h0);
      tick();
      bus.a_valid = 1'b0;
      chk("t2 rf_we", 64'(bus.rf_we), 64'h1);
      chk("t2 rf_adr", 64'(bus.rf_adr_wrt), 64'h5);
      chk("t2 rf_data", 64'(bus.rf_data_in), 64'hDEAD_BEEF);
      chk("t2 busy held", 64'(bus.busy_vec), 64'h0000_0020);
      tick();
      chk("t2 rf_we drop", 64'(bus.rf_we), 64'h0);
      chk("t2 busy clear", 64'(bus.busy_vec), 64'h0);
      chk("t2 adr hold", 64'(bus.rf_adr_wrt), 64'h5);
      chk("t2 data hold", 64'(bus.rf_data_in), 64'hDEAD_BEEF);

      // load/store write to x0: accepted, never written
      bus.b_valid = 1'b1; bus.b_rd = 5'd0; bus.b_data = 32'h0000_1234;
      #1 chk("t5 x0 b_ready", 64'(bus.b_ready), 64'h1);
      tick();
      bus.b_valid = 1'b0;
      chk("t5 x0 rf_we", 64'(bus.rf_we), 64'h0);
      chk("t5 x0 busy", 64'(bus.busy_vec), 64'h0);

      // contention: last winner was B, so A,B,A,B
      for (int i = 0; i < 4; i++) begin
         issue(5'd0, 5'd0, 5'(10 + i), 1'b1);
         tick();
      end
      chk("t3 busy 10-13", 64'(bus.busy_vec), 64'h0000_3C00);
      issue(5'd13, 5'd0, 5'd0, 1'b0);
      exp_adr = '{5'd10, 5'd11, 5'd12, 5'd13};
      exp_dat = '{32'hA000_0000, 32'hB000_0000, 32'hA000_0001, 32'hB000_0001};
      exp_ga  = '{1'b1, 1'b0, 1'b1, 1'b0};
      bus.a_valid = 1'b1; bus.a_rd = 5'd10; bus.a_data = 32'hA000_0000;
      bus.b_valid = 1'b1; bus.b_rd = 5'd11; bus.b_data = 32'hB000_0000;
      for (int c = 0; c < 4; c++) begin
         #1;
         chk($sformatf("t3 c%0d a_ready", c), 64'(bus.a_ready), 64'(exp_ga[c]));
         chk($sformatf("t3 c%0d b_ready", c), 64'(bus.b_ready), 64'(!exp_ga[c]));
         chk($sformatf("t3 c%0d stall", c), 64'(bus.iss_stall), 64'h1);
         tick();
         chk($sformatf("t3 c%0d rf_we", c), 64'(bus.rf_we), 64'h1);
         chk($sformatf("t3 c%0d rf_adr", c), 64'(bus.rf_adr_wrt), 64'(exp_adr[c]));
         chk($sformatf("t3 c%0d rf_data", c), 64'(bus.rf_data_in), 64'(exp_dat[c]));
         if (exp_ga[c]) begin
            bus.a_rd = 5'd12; bus.a_data = 32'hA000_0001;
            if (c == 2) bus.a_valid = 1'b0;
         end else begin
            bus.b_rd = 5'd13; bus.b_data = 32'hB000_0001;
            if (c == 3) bus.b_valid = 1'b0;
         end
      end
      bus.iss_valid = 1'b0;
      tick();
      chk("t3 rf_we drop", 64'(bus.rf_we), 64'h0);
      chk("t3 busy clear", 64'(bus.busy_vec), 64'h0);

      // RAW: x7 producer, then consumer reading x7
      issue(5'd0, 5'd0, 5'd7, 1'b1);
      tick();
      issue(5'd7, 5'd0, 5'd8, 1'b1);
      #1 chk("t4 stall busy", 64'(bus.iss_stall), 64'h1);
      tick();
      bus.a_valid = 1'b1; bus.a_rd = 5'd7; bus.a_data = 32'h0000_0077;
      #1 chk("t4 stall grant", 64'(bus.iss_stall), 64'h1);
      chk("t4 a_ready", 64'(bus.a_ready), 64'h1);
      tick();
      bus.a_valid = 1'b0;
      chk("t4 rf_adr", 64'(bus.rf_adr_wrt), 64'h7);
      #1 chk("t4 stall on write", 64'(bus.iss_stall), 64'h1);
      tick();
      chk("t4 stall after", 64'(bus.iss_stall), 64'h0);
      tick();
      bus.iss_valid = 1'b0;
      chk("t4 busy x8 only", 64'(bus.busy_vec), 64'h0000_0100);

      // WAW on x3 while its old write commits; reissue once it clears
      issue(5'd0, 5'd0, 5'd3, 1'b1);
      tick();
      bus.iss_valid = 1'b0;
      bus.a_valid = 1'b1; bus.a_rd = 5'd3; bus.a_data = 32'h0000_0033;
      tick();
      bus.a_valid = 1'b0;
      chk("t5 rf_adr x3", 64'(bus.rf_adr_wrt), 64'h3);
      issue(5'd0, 5'd0, 5'd3, 1'b1);
      #1 chk("t5 waw stall", 64'(bus.iss_stall), 64'h1);
      tick();
      chk("t5 busy x3 cleared", 64'(bus.busy_vec), 64'h0000_0100);
      chk("t5 reissue stall", 64'(bus.iss_stall), 64'h0);
      tick();
      bus.iss_valid = 1'b0;
      chk("t5 busy x3 ends set", 64'(bus.busy_vec), 64'h0000_0108);

      // WAW and no-write variants against busy {x3, x8}
      issue(5'd0, 5'd0, 5'd8, 1'b1);
      #1 chk("t6 waw stall", 64'(bus.iss_stall), 64'h1);
      issue(5'd0, 5'd0, 5'd8, 1'b0);
      #1 chk("t6 no-we no stall", 64'(bus.iss_stall), 64'h0);
      issue(5'd1, 5'd3, 5'd8, 1'b0);
      #1 chk("t6 rs2 stall", 64'(bus.iss_stall), 64'h1);
      bus.iss_valid = 1'b0;
      #1 chk("t6 no valid", 64'(bus.iss_stall), 64'h0);
      issue(5'd0, 5'd0, 5'd8, 1'b0);
      tick();
      chk("t6 busy unchanged", 64'(bus.busy_vec), 64'h0000_0108);

      // reset in the middle of a write with another request pending
      issue(5'd3, 5'd0, 5'd0, 1'b0);
      bus.a_valid = 1'b1; bus.a_rd = 5'd3; bus.a_data = 32'h0000_0333;
      tick();
      bus.a_rd = 5'd8; bus.a_data = 32'h0000_0888;
      #1 chk("t1 rf_we pre", 64'(bus.rf_we), 64'h1);
      chk("t1 a_ready pre", 64'(bus.a_ready), 64'h1);
      #2 reset = 1'b1;
      #1;
      chk("t1 rf_we", 64'(bus.rf_we), 64'h0);
      chk("t1 rf_adr", 64'(bus.rf_adr_wrt), 64'h0);
      chk("t1 rf_data", 64'(bus.rf_data_in), 64'h0);
      chk("t1 busy", 64'(bus.busy_vec), 64'h0);
      chk("t1 a_ready", 64'(bus.a_ready), 64'h0);
      chk("t1 b_ready", 64'(bus.b_ready), 64'h0);
      chk("t1 stall", 64'(bus.iss_stall), 64'h0);
      bus.iss_valid = 1'b0;
      bus.a_rd = 5'd0;
      bus.b_valid = 1'b1; bus.b_rd = 5'd0; bus.b_data = 32'h0000_0BBB;
      tick();
      chk("t1 rf_we held rst", 64'(bus.rf_we), 64'h0);
      reset = 1'b0;
      #1 chk("t1 first a_ready", 64'(bus.a_ready), 64'h1);
      chk("t1 first b_ready", 64'(bus.b_ready), 64'h0);
      tick();
      bus.a_valid = 1'b0;
      bus.b_valid = 1'b0;
      chk("t1 post rf_we", 64'(bus.rf_we), 64'h0);
      chk("t1 post busy", 64'(bus.busy_vec), 64'h0);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
